// File: rtl/mem_arbiter.sv
// Three-requester arbiter onto one shared single-port RAM.
// Round-robin grants, with an optional burst lock that keeps the RAM with one requester.
module mem_arbiter #(
  parameter int AW = 24,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [2:0]      lock,
  input  logic [3*AW-1:0] addr_i,
  input  logic [3*DW-1:0] wdata_i,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wren,
  output logic [DW-1:0]   mem_wrdata,
  input  logic [DW-1:0]   mem_rddata,
  output logic            busy
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [1:0] p_q, p_d;
  logic [1:0] o_q, o_d;
  logic [2:0] rvalid_q;
  logic [2:0] gnt_c;
  logic [1:0] gidx;
  logic [1:0] cand;
  logic       found;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    o_d     = o_q;
    gnt_c   = 3'b000;
    gidx    = 2'd0;
    cand    = p_q;
    found   = 1'b0;
    if (state_q == ARB) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && req[cand]) begin
          found = 1'b1;
          gidx  = cand;
        end
        cand = inc3(cand);
      end
      if (found) begin
        gnt_c = 3'b001 << gidx;
        if (lock[gidx]) begin
          o_d     = gidx;
          state_d = LOCKED;
        end else begin
          p_d = inc3(gidx);
        end
      end
    end else begin
      // Only the owner is looked at; everyone else stalls until it releases.
      gidx = o_q;
      if (req[o_q]) begin
        gnt_c = 3'b001 << o_q;
        if (!lock[o_q]) begin
          state_d = ARB;
          p_d     = inc3(o_q);
        end
      end
    end
    // Grants must not reach the RAM while reset is asserted.
    if (!rst_n) gnt_c = 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      p_q      <= 2'd0;
      o_q      <= 2'd0;
      rvalid_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      o_q      <= o_d;
      rvalid_q <= gnt_c & ~we;
    end
  end

  always_comb begin
    mem_addr   = '0;
    mem_wrdata = '0;
    mem_wren   = 1'b0;
    if (|gnt_c) begin
      mem_wren = we[gidx];
      case (gidx)
        2'd0:    begin mem_addr = addr_i[0*AW +: AW]; mem_wrdata = wdata_i[0*DW +: DW]; end
        2'd1:    begin mem_addr = addr_i[1*AW +: AW]; mem_wrdata = wdata_i[1*DW +: DW]; end
        default: begin mem_addr = addr_i[2*AW +: AW]; mem_wrdata = wdata_i[2*DW +: DW]; end
      endcase
    end
  end

  assign gnt    = gnt_c;
  assign rvalid = rvalid_q;
  assign rdata  = mem_rddata;
  assign busy   = (state_q == LOCKED) | (|gnt_c);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: round-robin order, writes, locks, pauses, reset.
module tb_mem_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req, we, lock;
  logic [3*AW-1:0] addr_i;
  logic [3*DW-1:0] wdata_i;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, mem_wrdata, mem_rddata;
  logic [AW-1:0]   mem_addr;
  logic            mem_wren, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] a0 = 24'h000A00;
  logic [AW-1:0] a1 = 24'h000010;
  logic [AW-1:0] a2 = 24'h0B0000;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wren(mem_wren),
    .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]    exp_g [5];
  logic [AW-1:0] exp_a [5];

  initial begin
    rst_n = 1'b0; req = '0; we = '0; lock = '0; mem_rddata = '0;
    addr_i  = {a2, a1, a0};
    wdata_i = {16'h3333, 16'hABCD, 16'h1111};
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_wrdata", mem_wrdata, 0);
    step(); step();
    rst_n = 1'b1;

    // All three reading: 0,1,2,0,1 and rvalid one cycle behind.
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    exp_a = '{a0, a1, a2, a0, a1};
    req = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("rr_gnt%0d", c), gnt, exp_g[c]);
      check($sformatf("rr_addr%0d", c), mem_addr, exp_a[c]);
      check($sformatf("rr_wren%0d", c), mem_wren, 0);
      check($sformatf("rr_rvalid%0d", c), rvalid, (c == 0) ? 3'b000 : exp_g[c-1]);
      step();
    end
    req = 3'b000;
    #1;
    check("rr_rvalid_tail", rvalid, 3'b010);
    check("idle_busy", busy, 0);

    // Write by requester 1 (pointer now at 2).
    req = 3'b010; we = 3'b010;
    #1;
    check("wr_gnt", gnt, 3'b010);
    check("wr_wren", mem_wren, 1);
    check("wr_addr", mem_addr, 24'h000010);
    check("wr_wdata", mem_wrdata, 16'hABCD);
    check("wr_busy", busy, 1);
    step();
    req = 3'b000; we = 3'b000;
    #1;
    check("wr_rvalid", rvalid, 0);

    // Requester 2 locks for four cycles while 0 waits.
    req = 3'b101; lock = 3'b100;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) lock = 3'b000;
      #1;
      check($sformatf("lk_gnt%0d", c), gnt, 3'b100);
      check($sformatf("lk_busy%0d", c), busy, 1);
      if (c > 1) check($sformatf("lk_rvalid%0d", c), rvalid, 3'b100);
      step();
    end
    req = 3'b001;
    #1;
    check("lk_gnt5", gnt, 3'b001);
    check("lk_addr5", mem_addr, a0);
    step();

    // Owner 0 pauses for two cycles; requester 1 must stall.
    req = 3'b001; lock = 3'b001;
    #1;
    check("pz_gnt_take", gnt, 3'b001);
    step();
    req = 3'b010;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("pz_gnt%0d", c), gnt, 3'b000);
      check($sformatf("pz_busy%0d", c), busy, 1);
      check($sformatf("pz_addr%0d", c), mem_addr, 0);
      step();
    end
    req = 3'b011; lock = 3'b000;
    #1;
    check("pz_gnt_release", gnt, 3'b001);
    step();
    #1;
    check("pz_gnt_after", gnt, 3'b010);
    step();
    req = 3'b000;

    // Requester 2 locks and reads; rddata passes through on rvalid.
    req = 3'b100; lock = 3'b100;
    #1;
    check("rd_gnt", gnt, 3'b100);
    step();
    mem_rddata = 16'h1234;
    #1;
    check("rd_rvalid", rvalid, 3'b100);
    check("rd_rdata", rdata, 16'h1234);
    check("rd_gnt_held", gnt, 3'b100);

    // Asynchronous reset in the middle of the locked read.
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_gnt", gnt, 0);
    check("ar_rvalid", rvalid, 0);
    check("ar_busy", busy, 0);
    check("ar_wren", mem_wren, 0);
    step();
    rst_n = 1'b1; req = 3'b111; lock = 3'b000; mem_rddata = '0;
    #1;
    check("ar_first_gnt", gnt, 3'b001);
    step();
    #1;
    check("ar_second_gnt", gnt, 3'b010);
    check("ar_rvalid_after", rvalid, 3'b001);
    step();
    req = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 24, width of every address field.
REQ-002 Parameter DW, default 16, width of every data field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  per-requester access request (bit0 boundingBox, bit1 header, bit2 cropping); held until granted.
REQ-006 we  input  3  per-requester write enable (1 write, 0 read), valid with req.
REQ-007 lock  input  3  per-requester burst lock, valid with req.
REQ-008 addr_i  input  3*AW  per-requester address, requester i at bits [i*AW +: AW].
REQ-009 wdata_i  input  3*DW  per-requester write data, requester i at bits [i*DW +: DW].
REQ-010 gnt  output  3  one-hot grant; access performed in the cycle gnt[i]=1.
REQ-011 rvalid  output  3  one-hot read-data-valid for the requester that read.
REQ-012 rdata  output  DW  read data, shared by all requesters.
REQ-013 mem_addr  output  AW  address to shared single-port RAM.
REQ-014 mem_wren  output  1  write enable to RAM.
REQ-015 mem_wrdata  output  DW  write data to RAM.
REQ-016 mem_rddata  input  DW  RAM read data, valid one cycle after address presented.
REQ-017 busy  output  1  high while any grant is active or a lock is held.

Function
REQ-018 Two states: ARB (free arbitration) and LOCKED (owner register o, 2 bits); round-robin pointer p, 2 bits, values 0..2 only.
REQ-019 gnt combinational from state, p, o, req; at most one bit set per cycle.
REQ-020 ARB: gnt to first requester with req=1 searching p, p+1, p+2 (mod 3); none -> gnt=0.
REQ-021 ARB, grant to i with lock[i]=0: p <= (i+1) mod 3, stay ARB.
REQ-022 ARB, grant to i with lock[i]=1: o <= i, go LOCKED; p unchanged.
REQ-023 LOCKED: gnt[o]=req[o]; other requesters never granted, their req ignored (stall).
REQ-024 LOCKED, cycle with req[o]=1 and lock[o]=0: access granted, then p <= (o+1) mod 3, go ARB.
REQ-025 LOCKED, req[o]=0: no grant, remain LOCKED (owner pause permitted).
REQ-026 Granted cycle: mem_addr=addr_i[i], mem_wrdata=wdata_i[i], mem_wren=we[i]; no grant: mem_addr=0, mem_wrdata=0, mem_wren=0.
REQ-027 rvalid[i] registered: 1 in cycle after gnt[i]=1 with we[i]=0, else 0; rdata=mem_rddata (combinational pass-through).
REQ-028 Read latency gnt->rvalid exactly 1 cycle; back-to-back reads by one requester sustain 1 access/cycle.
REQ-029 Fairness: with no locks, a held req granted within 3 cycles.
REQ-030 Simultaneous req from all three in ARB with p=0: grant order 0,1,2,0,...
REQ-031 busy = (state==LOCKED) | (|gnt).

Reset
REQ-032 rst_n=0 asynchronously forces state ARB, p=0, o=0, rvalid=0; with req=0 all outputs then read 0.
REQ-033 Reset mid-access or mid-lock: lock released, pending rvalid dropped; no write issued while rst_n=0 (gnt forced 0).
REQ-034 First arbitration after release: priority 0,1,2.

Verification
REQ-035 req=3'b111, we=0, lock=0, five cycles -> gnt 001,010,100,001,010; rvalid same sequence delayed 1 cycle.
REQ-036 req[1]=1, we[1]=1, addr=24'h000010, wdata=16'hABCD -> same cycle gnt=010, mem_wren=1, mem_addr=16, mem_wrdata=16'hABCD; next cycle rvalid=0.
REQ-037 req[2]=1 lock[2]=1 for 4 cycles, req[0]=1 throughout -> gnt=100 four cycles, lock[2]=0 on 4th; gnt=001 on 5th; busy=1 cycles 1-4.
REQ-038 LOCKED owner 0 drops req 2 cycles, req[1]=1 -> gnt=000 those cycles, busy=1, requester 1 not granted.
REQ-039 rst_n low mid-read during LOCKED owner 2 -> rvalid=0, gnt=0 immediately; after release, req=111 -> gnt=001.
REQ-040 mem_rddata=16'h1234 cycle after read grant to requester 2 -> rvalid=100, rdata=16'h1234.
